raptor64_bitfield_arb: RTL and testbench



---
 rtl/raptor64_bitfield_arb.sv | 142 ++++++++++++++
 tb/tb_raptor64_bitfield_arb.sv | 358 +++++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/raptor64_bitfield_arb.sv
`default_nettype none
// ============================================================================
//  Module   : raptor64_bitfield_arb
//  Purpose  : Round-robin two-port arbiter/sequencer in front of the Raptor64
//             combinational bitfield unit (latch, execute, return result).
//  Revision : 1.0 - initial release
// ============================================================================
module raptor64_bitfield_arb (
    input  logic        clk_i,
    input  logic        rst_ni,
    input  logic [1:0]  req_i,
    input  logic [31:0] ir0_i,
    input  logic [31:0] ir1_i,
    input  logic [63:0] a0_i,
    input  logic [63:0] a1_i,
    input  logic [63:0] b0_i,
    input  logic [63:0] b1_i,
    output logic [1:0]  ack_o,
    output logic [1:0]  vld_o,
    input  logic [1:0]  rdy_i,
    output logic [63:0] res_o,
    output logic        err_o,
    output logic        busy_o,
    output logic [31:0] bf_ir_o,
    output logic [63:0] bf_a_o,
    output logic [63:0] bf_b_o,
    input  logic [63:0] bf_o_i
);

    localparam logic [6:0] c_op_bitfield = 7'h22;
    localparam logic [2:0] c_bfins       = 3'd0;
    localparam logic [2:0] c_bfset       = 3'd1;
    localparam logic [2:0] c_bfclr       = 3'd2;
    localparam logic [2:0] c_bfchg       = 3'd3;
    localparam logic [2:0] c_bfext       = 3'd4;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        EXEC = 2'd1,
        DONE = 2'd2
    } state_e;

    state_e      state_q, state_d;
    logic        prio_q, prio_d;
    logic        gnt_q, gnt_d;
    logic        legal_q;
    logic [31:0] bf_ir_q;
    logic [63:0] bf_a_q, bf_b_q, res_q;
    logic        err_q;

    logic        w_pick;
    logic [31:0] w_ir;
    logic        w_legal;

    // A lone requester always wins; prio only breaks ties.
    assign w_pick = (req_i == 2'b10) ? 1'b1 :
                    (req_i == 2'b01) ? 1'b0 : prio_q;
    assign w_ir   = w_pick ? ir1_i : ir0_i;

    always_comb begin
        w_legal = 1'b0;
        if (w_ir[31:25] == c_op_bitfield) begin
            case (w_ir[2:0])
                c_bfins, c_bfset, c_bfclr, c_bfchg, c_bfext: w_legal = 1'b1;
                default:                                     w_legal = 1'b0;
            endcase
        end
    end

    always_comb begin
        state_d = state_q;
        prio_d  = prio_q;
        gnt_d   = gnt_q;
        ack_o   = 2'b00;
        vld_o   = 2'b00;
        case (state_q)
            IDLE: begin
                if (|req_i) begin
                    gnt_d   = w_pick;
                    state_d = EXEC;
                end
            end
            EXEC: begin
                ack_o[gnt_q] = 1'b1;
                state_d      = DONE;
            end
            DONE: begin
                vld_o[gnt_q] = 1'b1;
                if (rdy_i[gnt_q]) begin
                    prio_d  = ~gnt_q;
                    state_d = IDLE;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            state_q <= IDLE;
            prio_q  <= 1'b0;
            gnt_q   <= 1'b0;
        end else begin
            state_q <= state_d;
            prio_q  <= prio_d;
            gnt_q   <= gnt_d;
        end
    end

    // Operand registers feed the unit directly so its whole delay sits
    // between these flops and res_q.
    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            bf_ir_q <= '0;
            bf_a_q  <= '0;
            bf_b_q  <= '0;
            legal_q <= 1'b0;
            res_q   <= '0;
            err_q   <= 1'b0;
        end else begin
            if (state_q == IDLE && (|req_i)) begin
                bf_ir_q <= w_ir;
                bf_a_q  <= w_pick ? a1_i : a0_i;
                bf_b_q  <= w_pick ? b1_i : b0_i;
                legal_q <= w_legal;
            end
            if (state_q == EXEC) begin
                res_q <= legal_q ? bf_o_i : 64'd0;
                err_q <= ~legal_q;
            end
        end
    end

    assign res_o   = res_q;
    assign err_o   = err_q;
    assign busy_o  = (state_q != IDLE);
    assign bf_ir_o = bf_ir_q;
    assign bf_a_o  = bf_a_q;
    assign bf_b_o  = bf_b_q;

endmodule
`default_nettype wire

// File: tb/tb_raptor64_bitfield_arb.sv
`default_nettype none
// ============================================================================
//  Module   : tb_raptor64_bitfield_arb
//  Purpose  : Scoreboard bench for raptor64_bitfield_arb with a behavioural
//             bitfield unit attached to the bf_* ports.
//  Revision : 1.0 - initial release
// ============================================================================
module tb_raptor64_bitfield_arb;

    localparam logic [6:0] c_op_bf = 7'h22;
    localparam logic [2:0] c_ins = 3'd0, c_set = 3'd1, c_clr = 3'd2,
                           c_chg = 3'd3, c_ext = 3'd4;

    typedef struct {
        logic [1:0]  port;
        logic [63:0] res;
        logic        err;
    } sb_t;

    logic        clk = 1'b0;
    logic        rst_n;
    logic [1:0]  req, rdy, ack, vld;
    logic [31:0] ir0, ir1, bf_ir;
    logic [63:0] a0, a1, b0, b1, res, bf_a, bf_b, bf_o;
    logic        err, busy;
    int          n_chk = 0;
    int          n_bad = 0;
    int          cyc = 0;
    sb_t         sb[$];

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    raptor64_bitfield_arb dut (
        .clk_i(clk), .rst_ni(rst_n), .req_i(req),
        .ir0_i(ir0), .ir1_i(ir1), .a0_i(a0), .a1_i(a1), .b0_i(b0), .b1_i(b1),
        .ack_o(ack), .vld_o(vld), .rdy_i(rdy), .res_o(res), .err_o(err),
        .busy_o(busy), .bf_ir_o(bf_ir), .bf_a_o(bf_a), .bf_b_o(bf_b),
        .bf_o_i(bf_o)
    );

    function automatic logic [31:0] mk_ir(input logic [6:0] op, input logic [5:0] me,
                                          input logic [5:0] mb, input logic [2:0] f3);
        return {op, 10'b0, me, mb, f3};
    endfunction

    function automatic logic [63:0] bf_model(input logic [31:0] ir, input logic [63:0] a,
                                             input logic [63:0] b);
        int          mb = int'(ir[8:3]);
        int          me = int'(ir[14:9]);
        logic [63:0] mask = '0;
        for (int i = 0; i < 64; i++)
            if (i >= mb && i <= me) mask[i] = 1'b1;
        case (ir[2:0])
            c_ins:   return (b & ~mask) | ((a << mb) & mask);
            c_set:   return a | mask;
            c_clr:   return a & ~mask;
            c_chg:   return a ^ mask;
            c_ext:   return (a & mask) >> mb;
            default: return 64'hDEAD_BEEF_DEAD_BEEF;
        endcase
    endfunction

    assign bf_o = bf_model(bf_ir, bf_a, bf_b);

    task automatic issue(input int port, input logic [31:0] ir, input logic [63:0] a,
                         input logic [63:0] b, input bit push);
        sb_t e;
        bit  legal;
        if (port == 0) begin ir0 = ir; a0 = a; b0 = b; end
        else           begin ir1 = ir; a1 = a; b1 = b; end
        req[port] = 1'b1;
        if (push) begin
            legal  = (ir[31:25] == c_op_bf) && (ir[2:0] <= 3'd4);
            e.port = (port == 0) ? 2'b01 : 2'b10;
            e.res  = legal ? bf_model(ir, a, b) : 64'd0;
            e.err  = ~legal;
            sb.push_back(e);
        end
    endtask

    function automatic sb_t sb_pop();
        sb_t e;
        e.port = 2'b11; e.res = '1; e.err = 1'bx;
        if (sb.size() != 0) e = sb.pop_front();
        return e;
    endfunction

    // Waits (bounded) for ack_o or vld_o to become non-zero; 0 on timeout.
    task automatic wait_sig(input bit use_vld, output logic [1:0] seen);
        seen = 2'b00;
        for (int i = 0; i < 20; i++) begin
            @(negedge clk);
            if (use_vld ? (vld != 2'b00) : (ack != 2'b00)) begin
                seen = use_vld ? vld : ack;
                break;
            end
        end
    endtask

    task automatic test_reset();
        logic [1:0] s;
        rst_n = 1'b0;
        for (int i = 0; i < 4; i++) begin
            req = 2'($urandom); rdy = 2'($urandom);
            ir0 = $urandom; ir1 = $urandom;
            a0 = {$urandom, $urandom}; a1 = {$urandom, $urandom};
            b0 = {$urandom, $urandom}; b1 = {$urandom, $urandom};
            @(negedge clk);
        end
        n_chk++;
        if ({ack, vld, err, busy} !== 6'b0) begin
            n_bad++;
            $display("FAIL reset_ctl: ack=%b vld=%b err=%b busy=%b required all 0", ack, vld, err, busy);
        end
        n_chk++;
        if ({res, bf_ir, bf_a, bf_b} !== '0) begin
            n_bad++;
            $display("FAIL reset_data: res=%h bf_ir=%h bf_a=%h bf_b=%h required 0", res, bf_ir, bf_a, bf_b);
        end
        req = 2'b00; rdy = 2'b11;
        @(negedge clk); rst_n = 1'b1;
        @(negedge clk);
        issue(0, mk_ir(c_op_bf, 6'd7, 6'd4, c_set), 64'd0, 64'd0, 1'b0);
        wait_sig(1'b0, s);
        n_chk++;
        if (s !== 2'b01) begin
            n_bad++;
            $display("FAIL abort_ack: ack=%b required 01", s);
        end
        req = 2'b00;
        rst_n = 1'b0;
        #1;
        n_chk++;
        if (busy !== 1'b0) begin
            n_bad++;
            $display("FAIL abort_busy: busy=%b required 0", busy);
        end
        for (int i = 0; i < 5; i++) begin
            @(negedge clk);
            if (i == 1) rst_n = 1'b1;
            n_chk++;
            if (vld !== 2'b00) begin
                n_bad++;
                $display("FAIL abort_vld: cycle %0d vld=%b required 00", i, vld);
            end
        end
    endtask

    task automatic test_bfset();
        logic [1:0] s;
        sb_t        e;
        rdy = 2'b11;
        issue(0, mk_ir(c_op_bf, 6'd7, 6'd4, c_set), 64'd0, 64'd0, 1'b1);
        wait_sig(1'b0, s);
        n_chk++;
        if (s !== 2'b01) begin
            n_bad++;
            $display("FAIL bfset_ack: ack=%b required 01", s);
        end
        req = 2'b00;
        @(negedge clk);
        n_chk++;
        if (ack !== 2'b00 || vld !== 2'b01) begin
            n_bad++;
            $display("FAIL bfset_timing: ack=%b vld=%b required ack=00 vld=01", ack, vld);
        end
        e = sb_pop();
        n_chk++;
        if (vld !== e.port || res !== e.res || err !== e.err || res !== 64'hF0) begin
            n_bad++;
            $display("FAIL bfset_sb: vld=%b res=%h err=%b required vld=%b res=%h err=%b",
                     vld, res, err, e.port, e.res, e.err);
        end
        @(negedge clk);
        n_chk++;
        if (vld !== 2'b00 || busy !== 1'b0) begin
            n_bad++;
            $display("FAIL bfset_done: vld=%b busy=%b required vld=00 busy=0", vld, busy);
        end
    endtask

    task automatic test_backpressure();
        logic [1:0]  s;
        logic [63:0] hold;
        sb_t         e;
        rdy = 2'b00;
        issue(1, mk_ir(c_op_bf, 6'd11, 6'd4, c_ext), 64'h1234, 64'd0, 1'b1);
        wait_sig(1'b0, s);
        n_chk++;
        if (s !== 2'b10) begin
            n_bad++;
            $display("FAIL bp_ack1: ack=%b required 10", s);
        end
        req[1] = 1'b0;
        issue(0, mk_ir(c_op_bf, 6'd3, 6'd0, c_set), 64'h100, 64'd0, 1'b1);
        wait_sig(1'b1, s);
        e = sb_pop();
        n_chk++;
        if (s !== e.port || res !== e.res || err !== e.err || res !== 64'h23) begin
            n_bad++;
            $display("FAIL bp_ext_sb: vld=%b res=%h err=%b required vld=%b res=%h err=%b",
                     s, res, err, e.port, e.res, e.err);
        end
        hold = res;
        for (int i = 0; i < 5; i++) begin
            @(negedge clk);
            n_chk++;
            if (res !== hold || ack !== 2'b00 || vld !== 2'b10) begin
                n_bad++;
                $display("FAIL bp_stall: cycle %0d res=%h ack=%b vld=%b required res=%h ack=00 vld=10",
                         i, res, ack, vld, hold);
            end
        end
        rdy = 2'b10;
        @(negedge clk);
        n_chk++;
        if (vld !== 2'b00) begin
            n_bad++;
            $display("FAIL bp_release: vld=%b required 00", vld);
        end
        wait_sig(1'b0, s);
        n_chk++;
        if (s !== 2'b01) begin
            n_bad++;
            $display("FAIL bp_ack0: ack=%b required 01", s);
        end
        req[0] = 1'b0; rdy = 2'b11;
        wait_sig(1'b1, s);
        e = sb_pop();
        n_chk++;
        if (s !== e.port || res !== e.res || err !== e.err) begin
            n_bad++;
            $display("FAIL bp_set_sb: vld=%b res=%h err=%b required vld=%b res=%h err=%b",
                     s, res, err, e.port, e.res, e.err);
        end
        @(negedge clk);
    endtask

    task automatic test_contention();
        logic [1:0] s;
        sb_t        e;
        int         last;
        rst_n = 1'b0;
        @(negedge clk); rst_n = 1'b1;
        @(negedge clk);
        rdy = 2'b11;
        for (int k = 0; k < 4; k++) begin
            if (k % 2 == 0) issue(0, mk_ir(c_op_bf, 6'd7, 6'd0, c_chg), 64'hAAAA, 64'd0, 1'b1);
            else            issue(1, mk_ir(c_op_bf, 6'd63, 6'd60, c_clr), '1, 64'd0, 1'b1);
        end
        last = 0;
        for (int k = 0; k < 4; k++) begin
            wait_sig(1'b0, s);
            n_chk++;
            if (s !== ((k % 2 == 0) ? 2'b01 : 2'b10)) begin
                n_bad++;
                $display("FAIL cont_order: op %0d ack=%b required %b", k, s,
                         (k % 2 == 0) ? 2'b01 : 2'b10);
            end
            if (k > 0) begin
                n_chk++;
                if (cyc - last !== 3) begin
                    n_bad++;
                    $display("FAIL cont_interval: op %0d interval=%0d required 3", k, cyc - last);
                end
            end
            last = cyc;
            if (k == 3) req = 2'b00;
            wait_sig(1'b1, s);
            e = sb_pop();
            n_chk++;
            if (s !== e.port || res !== e.res || err !== e.err) begin
                n_bad++;
                $display("FAIL cont_sb: op %0d vld=%b res=%h err=%b required vld=%b res=%h err=%b",
                         k, s, res, err, e.port, e.res, e.err);
            end
        end
        @(negedge clk);
    endtask

    task automatic test_illegal();
        logic [1:0]  s;
        sb_t         e;
        int          port[4] = '{0, 1, 0, 1};
        logic [31:0] ir[4];
        ir[0] = mk_ir(c_op_bf, 6'd15, 6'd8, c_clr);
        ir[1] = mk_ir(7'h23,   6'd15, 6'd8, c_set);
        ir[2] = mk_ir(c_op_bf, 6'd15, 6'd8, 3'd7);
        ir[3] = mk_ir(c_op_bf, 6'd15, 6'd8, 3'd5);
        rdy = 2'b11;
        for (int k = 0; k < 4; k++) begin
            issue(port[k], ir[k], 64'h0123_4567_89AB_CDEF, 64'd0, 1'b1);
            wait_sig(1'b0, s);
            req = 2'b00;
            wait_sig(1'b1, s);
            e = sb_pop();
            n_chk++;
            if (s !== e.port || res !== e.res || err !== e.err) begin
                n_bad++;
                $display("FAIL illegal_sb: op %0d vld=%b res=%h err=%b required vld=%b res=%h err=%b",
                         k, s, res, err, e.port, e.res, e.err);
            end
            @(negedge clk);
        end
    endtask

    task automatic test_bfins();
        logic [1:0]   s;
        sb_t          e;
        logic [159:0] snap;
        rdy = 2'b00;
        issue(0, mk_ir(c_op_bf, 6'd11, 6'd8, c_ins), 64'h5, '1, 1'b1);
        wait_sig(1'b0, s);
        req = 2'b00;
        snap = {bf_ir, bf_a, bf_b};
        wait_sig(1'b1, s);
        e = sb_pop();
        n_chk++;
        if (s !== e.port || res !== e.res || err !== e.err || res !== 64'hFFFF_FFFF_FFFF_F5FF) begin
            n_bad++;
            $display("FAIL bfins_sb: vld=%b res=%h err=%b required vld=%b res=%h err=%b",
                     s, res, err, e.port, e.res, e.err);
        end
        for (int i = 0; i < 3; i++) begin
            @(negedge clk);
            n_chk++;
            if ({bf_ir, bf_a, bf_b} !== snap) begin
                n_bad++;
                $display("FAIL bfins_hold: cycle %0d bf=%h required %h", i, {bf_ir, bf_a, bf_b}, snap);
            end
        end
        rdy = 2'b11;
        @(negedge clk);
        n_chk++;
        if (vld !== 2'b00 || busy !== 1'b0) begin
            n_bad++;
            $display("FAIL bfins_done: vld=%b busy=%b required vld=00 busy=0", vld, busy);
        end
    endtask

    initial begin
        req = 2'b00; rdy = 2'b00;
        ir0 = '0; ir1 = '0; a0 = '0; a1 = '0; b0 = '0; b1 = '0;
        rst_n = 1'b0;
        @(negedge clk);
        test_reset();
        test_bfset();
        test_backpressure();
        test_contention();
        test_illegal();
        test_bfins();
        $display("test done: total=%0d bad=%0d", n_chk, n_bad);
        $finish;
    end

endmodule
`default_nettype wire
